// File: rtl/modmul_pipe_pkg.sv
`default_nettype none
// modmul_pipe_pkg: shared constants and types for the Kyber-modulus multiplier pipeline.
// Rev 1.0
package modmul_pipe_pkg;

  localparam int KYBER_Q  = 3329;
  localparam int KYBER_QW = 12;
  localparam int PROD_W   = 24;

  // Barrett reduction: q ~= floor(x * M / 2^K), underestimates by at most 1 for x < 2^24.
  localparam int          BARRETT_K = 36;
  localparam int          BARRETT_W = 49;
  localparam logic [24:0] BARRETT_M = 25'd20642678;

  typedef logic [KYBER_QW-1:0] coeff_t;
  typedef logic [PROD_W-1:0]   prod_t;

endpackage
`default_nettype wire

// File: rtl/modmul_pipe_modred.sv
`default_nettype none
// modred: combinational 24-bit to 12-bit reduction modulo 3329 (Barrett plus one correction).
// Rev 1.0
module modred
  import modmul_pipe_pkg::*;
(
  input  logic [PROD_W-1:0]   x,
  output logic [KYBER_QW-1:0] y
);

  logic [BARRETT_W-1:0] w_prod;
  logic [12:0]          w_q;
  logic [PROD_W-1:0]    w_qq;
  logic [12:0]          w_t;
  logic [12:0]          w_t_sub;

  assign w_prod  = BARRETT_W'(x) * BARRETT_W'(BARRETT_M);
  assign w_q     = 13'(w_prod >> BARRETT_K);
  assign w_qq    = PROD_W'(w_q) * PROD_W'(KYBER_Q);
  // Remainder lies in [0, 2q) because the quotient estimate is short by at most one.
  assign w_t     = 13'(x - w_qq);
  assign w_t_sub = w_t - 13'(KYBER_Q);
  assign y       = (w_t >= 13'(KYBER_Q)) ? KYBER_QW'(w_t_sub) : KYBER_QW'(w_t);

endmodule
`default_nettype wire

// File: rtl/modmul_pipe.sv
`default_nettype none
// modmul_pipe: 3-stage r = (a*b [+acc]) mod 3329 pipeline with valid/ready backpressure.
// Rev 1.0. Option macro MODMUL_ACC_EN adds the acc addend port.
module modmul_pipe
  import modmul_pipe_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KYBER_QW-1:0] a,
  input  logic [KYBER_QW-1:0] b,
`ifdef MODMUL_ACC_EN
  input  logic [KYBER_QW-1:0] acc,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [KYBER_QW-1:0] r,
  output logic [CNT_W-1:0]    op_count
);

  logic                r_v1, r_v2, r_v3;
  coeff_t              r_a1, r_b1;
`ifdef MODMUL_ACC_EN
  coeff_t              r_acc1;
`endif
  prod_t               r_p2;
  coeff_t              r_r3;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_stall;
  prod_t               w_p1;
  coeff_t              w_red;

  // Reset masks the output so no handshake can complete on a reset cycle.
  assign out_valid = r_v3 & ~reset;
  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign r         = r_r3;
  assign op_count  = r_cnt;

`ifdef MODMUL_ACC_EN
  assign w_p1 = PROD_W'(r_a1) * PROD_W'(r_b1) + PROD_W'(r_acc1);
`else
  assign w_p1 = PROD_W'(r_a1) * PROD_W'(r_b1);
`endif

  modred u_modred (
    .x (r_p2),
    .y (w_red)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
`ifdef MODMUL_ACC_EN
      r_acc1 <= '0;
`endif
      r_p2   <= '0;
      r_r3   <= '0;
    end else if (!w_stall) begin
      r_v1   <= in_valid;
      r_a1   <= a;
      r_b1   <= b;
`ifdef MODMUL_ACC_EN
      r_acc1 <= acc;
`endif
      r_v2   <= r_v1;
      r_p2   <= w_p1;
      r_v3   <= r_v2;
      r_r3   <= w_red;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_modmul_pipe.sv
`default_nettype none
// tb_modmul_pipe: directed self-checking bench for modmul_pipe (default and CNT_W=4 instances).
// Rev 1.0
module tb_modmul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] a;
  logic [11:0] b;
`ifdef MODMUL_ACC_EN
  logic [11:0] acc;
`endif

  logic        in_ready, out_valid;
  logic [11:0] r;
  logic [15:0] op_count;

  logic        in_ready4, out_valid4;
  logic [11:0] r4;
  logic [3:0]  op_count4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] sa   [5] = '{12'd2, 12'd100, 12'd3000, 12'd50, 12'd1};
  logic [11:0] sb   [5] = '{12'd3, 12'd100, 12'd2,    12'd67, 12'd1};
  logic [11:0] sexp [5] = '{12'd6, 12'd13,  12'd2671, 12'd21, 12'd1};

  always #5 clk = ~clk;

  modmul_pipe u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MODMUL_ACC_EN
    .acc       (acc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .op_count  (op_count)
  );

  modmul_pipe #(.CNT_W(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .a         (a),
    .b         (b),
`ifdef MODMUL_ACC_EN
    .acc       (acc),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .r         (r4),
    .op_count  (op_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] aa, input logic [11:0] bb);
    in_valid = v;
    a        = aa;
    b        = bb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          sent;
    int          got;
    int          stall_left;
    int          n_stalled;
    bit          held;
    logic [11:0] held_r;

    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 12'd0, 12'd0);
`ifdef MODMUL_ACC_EN
    acc = 12'd0;
`endif
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    #1;
    check("rst_op_count", op_count, 0);
    check("rst_r", r, 0);
    check("rst_out_valid_after", out_valid, 0);

    // Single operation and its latency.
    drive(1'b1, 12'd17, 12'd1000);
    #1;
    check("t1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("lat_c1", out_valid, 0);
    tick();
    check("lat_c2", out_valid, 0);
    tick();
    check("lat_c3", out_valid, 1);
    check("t1_r", r, 355);
    tick();
    check("t1_op_count", op_count, 1);
    check("t1_drained", out_valid, 0);

    // Back-to-back operations, one result per cycle.
    drive(1'b1, 12'd3328, 12'd3328);
    tick();
    drive(1'b1, 12'd0, 12'd2500);
    tick();
    drive(1'b1, 12'd1234, 12'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_v0", out_valid, 1);
    check("b2b_r0", r, 1);
    tick();
    check("b2b_v1", out_valid, 1);
    check("b2b_r1", r, 0);
    tick();
    check("b2b_v2", out_valid, 1);
    check("b2b_r2", r, 1234);
    tick();
    check("b2b_drained", out_valid, 0);
    check("b2b_op_count", op_count, 4);

    // Five inputs with a four-cycle output stall after the first result.
    sent = 0; got = 0; stall_left = -1; n_stalled = 0; held = 1'b0; held_r = '0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (held) begin
        check("stall_r_held", r, held_r);
        check("stall_ov_held", out_valid, 1);
      end
      if (stall_left < 0 && out_valid) stall_left = 4;
      out_ready = !(stall_left > 0);
      if (stall_left > 0) stall_left--;
      in_valid = (sent < 5);
      if (sent < 5) begin
        a = sa[sent];
        b = sb[sent];
      end
      #1;
      if (!out_ready) begin
        check("stall_in_ready", in_ready, 0);
        n_stalled++;
      end
      held   = out_valid && !out_ready;
      held_r = r;
      if (out_valid && out_ready) begin
        check("stall_order", r, sexp[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall_count", got, 5);
    check("stall_cycles", n_stalled, 4);
    tick();
    check("stall_no_dup", out_valid, 0);
    check("stall_op_count", op_count, 9);

    // Reset with three operations in flight.
    drive(1'b1, 12'd5, 12'd5);
    tick();
    drive(1'b1, 12'd6, 12'd6);
    tick();
    drive(1'b1, 12'd7, 12'd7);
    tick();
    check("flight_ov", out_valid, 1);
    reset = 1'b1;
    drive(1'b1, 12'd9, 12'd9);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("postrst_out_valid", out_valid, 0);
    check("postrst_op_count", op_count, 0);
    check("postrst_op_count4", op_count4, 0);
    check("postrst_r", r, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_stale", out_valid, 0);
    end

    // Counter wrap on the CNT_W=4 instance: 17 results.
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 17; cyc++) begin
      in_valid = (sent < 17);
      a = 12'(sent + 1);
      b = 12'd1;
      #1;
      if (out_valid) begin
        check("wrap_r", r, got + 1);
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    check("wrap_count", got, 17);
    check("wrap_op_count16", op_count, 17);
    check("wrap_op_count4", op_count4, 1);

`ifdef MODMUL_ACC_EN
    drive(1'b1, 12'd3328, 12'd3328);
    acc = 12'd3328;
    tick();
    drive(1'b1, 12'd17, 12'd1000);
    acc = 12'd10;
    tick();
    in_valid = 1'b0;
    acc      = 12'd0;
    tick();
    check("acc_v0", out_valid, 1);
    check("acc_r0", r, 0);
    tick();
    check("acc_v1", out_valid, 1);
    check("acc_r1", r, 365);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/modmul_pipe.md
MODMUL_PIPE -- requirements
Module: modmul_pipe

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port a  input  12  operand A, value 0..3328.
REQ-007 SHALL have port b  input  12  operand B, value 0..3328.
REQ-008 SHALL have port acc  input  12  addend, value 0..3328; present only with MODMUL_ACC_EN.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port r  output  12  result, value 0..3328.
REQ-012 SHALL have port op_count  output  CNT_W  number of results delivered since reset.

Function
REQ-013 SHALL compute r = (a*b) mod 3329 for each accepted operand pair.
REQ-014 SHALL be a 3-stage pipeline: S1 operand register, S2 24-bit product register, S3 reduced-result register.
REQ-015 SHALL have a latency of exactly 3 cycles from input handshake (in_valid&&in_ready) to out_valid with no stall.
REQ-016 SHALL form the S2 product as an unsigned 24-bit value; SHALL not truncate before reduction.
REQ-017 SHALL carry a valid bit per stage; S3 valid drives out_valid.
REQ-018 SHALL define stall = out_valid && !out_ready; while stall is high, all stage registers and valid bits SHALL hold.
REQ-019 SHALL drive in_ready = !stall, combinationally.
REQ-020 SHALL let bubbles advance: with no stall, an invalid stage is overwritten regardless of downstream state.
REQ-021 SHALL keep r and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL sustain one result per cycle when in_valid and out_ready stay high.
REQ-023 SHALL increment op_count by 1 on each output handshake (out_valid&&out_ready) and wrap from 2^CNT_W-1 to 0.
REQ-024 SHALL treat operands >= 3329 as out of contract; the result is unspecified but the pipeline SHALL not lock up.

Reset
REQ-025 SHALL clear all valid bits, r, and op_count to 0 on a reset cycle. With reset high, out_valid=0 and in_ready=1.
REQ-026 SHALL discard in-flight operations on reset mid-operation, with no output handshake for them afterwards.
REQ-027 SHALL ignore an input handshake in the same cycle as reset.

Configuration
REQ-028 SHALL use macro MODMUL_ACC_EN.
REQ-029 With MODMUL_ACC_EN defined, SHALL register acc in S1 and compute r = (a*b+acc) mod 3329, with the 24-bit sum formed in S2. The maximum sum is 11078912, so there is no overflow.
REQ-030 With MODMUL_ACC_EN undefined, the acc port and its register SHALL not exist and the behaviour SHALL be REQ-013.
REQ-031 SHALL keep latency and handshake behaviour identical in both builds.

Structure
REQ-032 SHALL place KYBER_Q=3329, KYBER_QW=12, and PROD_W=24 constants in a shared package.
REQ-033 SHALL instantiate the existing combinational 24-to-12-bit reduction module modred between S2 and S3 as its single sub-module.
REQ-034 SHALL not instantiate any other sub-module. The multiplier is inferred.

Verification
REQ-035 SHALL cover: reset, then a=17, b=1000 with out_ready=1 -> r=355, out_valid exactly 3 cycles after handshake, op_count=1.
REQ-036 SHALL cover: a=3328, b=3328 -> r=1; a=0, b=2500 -> r=0; a=1234, b=1 -> r=1234 on back-to-back cycles, all in order, one result per cycle.
REQ-037 SHALL cover: 5 back-to-back inputs with out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 during the stall, r held, no loss or duplication, order preserved.
REQ-038 SHALL cover: reset asserted while 3 operations are in flight -> out_valid=0 the next cycle, op_count=0, no stale result ever emerges.
REQ-039 SHALL cover: CNT_W=4, 17 results -> op_count=1 after the wrap.
REQ-040 SHALL cover, with MODMUL_ACC_EN: a=3328, b=3328, acc=3328 -> r=0; a=17, b=1000, acc=10 -> r=365.
